multicycle_sequencer: RTL and testbench
=======================================

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 The module SHALL have the following ports (name, direction, width, meaning):
REQ-002 clk  input  1  single clock; all state updates occur on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  7  instruction[6:0] from the instruction register, valid from ID onward.
REQ-005 bcond  input  1  branch-taken flag from the ALU, valid in EX_1.
REQ-006 halt_req  input  1  datapath flag that ecall is a halt ecall (x17 == 10), valid in ID.
REQ-007 mem_ready  input  1  memory access-complete handshake, sampled only in IF and MEM.
REQ-008 current_state  output  3  state code driven to the micro-controller.
REQ-009 is_halted  output  1  sticky halt indication.
REQ-010 illegal_inst  output  1  sticky flag, set when halted on an unknown opcode.
REQ-011 cycle_cnt  output  32  count of non-halted clock cycles.
REQ-012 instret_cnt  output  32  count of retired instructions.

Function
REQ-013 State codes SHALL be: IF=0, ID=1, EX_1=2, EX_2=3, MEM=4, WB=5, HALT=6; code 7 is unused and SHALL go to HALT with illegal_inst set.
REQ-014 Opcodes SHALL be: ARITHMETIC 0110011, ARITHMETIC_IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, ECALL 1110011.
REQ-015 IF SHALL go to ID when mem_ready=1, and SHALL stay in IF otherwise.
REQ-016 ID transitions SHALL be: ECALL with halt_req=1 -> HALT; ECALL with halt_req=0 -> IF; a listed non-ECALL opcode -> EX_1; any other opcode -> HALT with illegal_inst set.
REQ-017 EX_1 transitions SHALL be: ARITHMETIC, ARITHMETIC_IMM, JAL or JALR -> WB; LOAD or STORE -> MEM; BRANCH with bcond=1 -> EX_2; BRANCH with bcond=0 -> IF.
REQ-018 EX_2 SHALL go to IF unconditionally.
REQ-019 MEM SHALL hold while mem_ready=0; when mem_ready=1, LOAD -> WB and STORE -> IF.
REQ-020 WB SHALL go to IF unconditionally.
REQ-021 HALT SHALL be terminal until reset; all inputs are ignored while in HALT.
REQ-022 current_state SHALL be the registered state, so control outputs change one edge after the transition condition is sampled.
REQ-023 Minimum latency in cycles, each with mem_ready=1 throughout, SHALL be:
- arithmetic, JAL, JALR: 4
- branch not taken: 3
- branch taken: 4
- store: 4
- load: 5
- non-halt ecall: 2
REQ-024 A retire event SHALL occur on each edge that moves the state into IF from ID, EX_1, EX_2, MEM or WB, and on the ID->HALT transition taken for ECALL with halt_req=1.
REQ-025 The ID->HALT transition taken for an illegal opcode SHALL NOT be a retire event.
REQ-026 instret_cnt SHALL increment by 1 on each retire event and wrap from 0xFFFFFFFF to 0.
REQ-027 cycle_cnt SHALL increment by 1 on every rising edge on which the pre-edge state is not HALT, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-028 is_halted SHALL be 1 exactly when the state is HALT.
REQ-029 illegal_inst SHALL remain 1 once set, until reset.
REQ-030 mem_ready asserted in any state other than IF or MEM SHALL have no effect.

Reset
REQ-031 reset=0 SHALL immediately and asynchronously force:
- state to IF
- is_halted=0
- illegal_inst=0
- cycle_cnt=0
- instret_cnt=0
REQ-032 Reset asserted mid-instruction (including during a MEM wait) SHALL abandon the instruction, and that instruction SHALL NOT be counted as retired.
REQ-033 After reset is released, the first state change SHALL occur on the first rising edge at which reset=1.

Verification
REQ-034 ADD (0110011), mem_ready=1 -> states IF,ID,EX_1,WB,IF; instret_cnt=1 and cycle_cnt=4 at the second IF.
REQ-035 BRANCH, bcond=0, then BRANCH, bcond=1 -> sequences IF,ID,EX_1,IF and IF,ID,EX_1,EX_2,IF; instret_cnt=2 and cycle_cnt=7.
REQ-036 LOAD with mem_ready low for 3 cycles in MEM -> MEM held 4 cycles, then WB,IF; instret_cnt=1 and cycle_cnt=8.
REQ-037 ECALL with halt_req=0, then ECALL with halt_req=1 -> IF,ID,IF,ID,HALT; is_halted=1, instret_cnt=2, and cycle_cnt frozen at 4 over 10 further edges.
REQ-038 opcode 0000000 in ID -> HALT with illegal_inst=1 and instret_cnt unchanged.
REQ-039 reset pulled low asynchronously while in MEM -> state=IF and all counters 0 before the next edge; normal fetch resumes after release.
REQ-040 With instret_cnt preloaded to 0xFFFFFFFF through a hierarchical force, one retire -> instret_cnt=0.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle RV32 control sequencer with cycle/instret counters
//
// Purpose: steps each instruction through IF/ID/EX_1/EX_2/MEM/WB, halts on a
// halt ecall or an unknown opcode, and counts active cycles and retirements.
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   opcode[6:0]   instruction[6:0], valid from ID onward
//   bcond         branch-taken flag, valid in EX_1
//   halt_req      ecall is a halt ecall, valid in ID
//   mem_ready     memory handshake, sampled only in IF and MEM
//   current_state registered state code
//   is_halted     high while in HALT
//   illegal_inst  sticky unknown-opcode flag
//   cycle_cnt     non-halted cycle count (wraps)
//   instret_cnt   retired instruction count (wraps)
module multicycle_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        bcond,
  input  logic        halt_req,
  input  logic        mem_ready,
  output logic [2:0]  current_state,
  output logic        is_halted,
  output logic        illegal_inst,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX_1 = 3'd2;
  localparam logic [2:0] S_EX_2 = 3'd3;
  localparam logic [2:0] S_MEM  = 3'd4;
  localparam logic [2:0] S_WB   = 3'd5;
  localparam logic [2:0] S_HALT = 3'd6;

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  logic [2:0]  state_q, state_d;
  logic        illegal_q, illegal_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instret_cnt_q, instret_cnt_d;
  logic        retire;
  logic        is_exec_op;

  // Opcodes that proceed from ID into EX_1 (everything listed except ECALL).
  always_comb begin
    is_exec_op = 1'b0;
    case (opcode)
      OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_JALR: is_exec_op = 1'b1;
      default:                    is_exec_op = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      S_IF: begin
        if (mem_ready) state_d = S_ID;
      end
      S_ID: begin
        if (opcode == OP_ECALL) begin
          // A halt ecall still completes, so it retires on the way to HALT.
          state_d = halt_req ? S_HALT : S_IF;
          retire  = 1'b1;
        end else if (is_exec_op) begin
          state_d = S_EX_1;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_EX_1: begin
        case (opcode)
          OP_ARITH, OP_ARITH_IMM, OP_JAL, OP_JALR: state_d = S_WB;
          OP_LOAD, OP_STORE:                       state_d = S_MEM;
          OP_BRANCH: begin
            state_d = bcond ? S_EX_2 : S_IF;
            retire  = !bcond;
          end
          default: begin
            // Opcode changed under us after decode; treat as illegal.
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EX_2: begin
        state_d = S_IF;
        retire  = 1'b1;
      end
      S_MEM: begin
        if (mem_ready) begin
          if (opcode == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            state_d = S_IF;
            retire  = 1'b1;
          end
        end
      end
      S_WB: begin
        state_d = S_IF;
        retire  = 1'b1;
      end
      S_HALT: state_d = S_HALT;
      default: begin
        state_d   = S_HALT;
        illegal_d = 1'b1;
      end
    endcase

    cycle_cnt_d   = (state_q != S_HALT) ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
    instret_cnt_d = retire ? instret_cnt_q + 32'd1 : instret_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IF;
      illegal_q     <= 1'b0;
      cycle_cnt_q   <= 32'd0;
      instret_cnt_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      illegal_q     <= illegal_d;
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign current_state = state_q;
  assign is_halted     = (state_q == S_HALT);
  assign illegal_inst  = illegal_q;
  assign cycle_cnt     = cycle_cnt_q;
  assign instret_cnt   = instret_cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic        bcond;
  logic        halt_req;
  logic        mem_ready;
  logic [2:0]  current_state;
  logic        is_halted;
  logic        illegal_inst;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;

  multicycle_sequencer dut (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond),
    .halt_req(halt_req), .mem_ready(mem_ready),
    .current_state(current_state), .is_halted(is_halted),
    .illegal_inst(illegal_inst), .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_cyc;
  logic [31:0] m_ret;
  bit          m_ill;

  localparam logic [6:0] ARITH = 7'b0110011, ARITH_IMM = 7'b0010011,
                         LOAD = 7'b0000011, STORE = 7'b0100011,
                         BRANCH = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, ECALL = 7'b1110011;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit listed(input logic [6:0] op);
    return op inside {ARITH, ARITH_IMM, LOAD, STORE, BRANCH, JAL, JALR, ECALL};
  endfunction

  task automatic check_outputs(input string tag, input logic [2:0] st);
    chk({tag, ".state"}, current_state, st);
    chk({tag, ".halted"}, is_halted, st == 3'd6);
    chk({tag, ".illegal"}, illegal_inst, m_ill);
    chk({tag, ".cycle"}, cycle_cnt, m_cyc);
    chk({tag, ".instret"}, instret_cnt, m_ret);
  endtask

  // Called at a negedge with the DUT in IF. Builds the expected per-cycle
  // state list from the instruction class, then drives and checks it.
  task automatic run_instr(input logic [6:0] op, input bit bc, input bit hr,
                           input int w_if, input int w_mem);
    logic [2:0] st_q[$];
    bit         rd_q[$];
    logic [2:0] end_st;
    bit         ret;
    for (int i = 0; i < w_if; i++) begin st_q.push_back(3'd0); rd_q.push_back(1'b0); end
    st_q.push_back(3'd0); rd_q.push_back(1'b1);
    st_q.push_back(3'd1); rd_q.push_back(1'b0);
    end_st = 3'd0;
    ret    = 1'b1;
    if (op == ECALL) begin
      end_st = hr ? 3'd6 : 3'd0;
    end else if (!listed(op)) begin
      end_st = 3'd6;
      ret    = 1'b0;
    end else begin
      st_q.push_back(3'd2); rd_q.push_back(1'b0);
      if (op == LOAD || op == STORE) begin
        for (int i = 0; i < w_mem; i++) begin st_q.push_back(3'd4); rd_q.push_back(1'b0); end
        st_q.push_back(3'd4); rd_q.push_back(1'b1);
        if (op == LOAD) begin st_q.push_back(3'd5); rd_q.push_back(1'b0); end
      end else if (op == BRANCH) begin
        if (bc) begin st_q.push_back(3'd3); rd_q.push_back(1'b0); end
      end else begin
        st_q.push_back(3'd5); rd_q.push_back(1'b0);
      end
    end
    foreach (st_q[i]) begin
      chk("seq.state", current_state, st_q[i]);
      mem_ready = (st_q[i] == 3'd0 || st_q[i] == 3'd4) ? rd_q[i] : 1'($urandom);
      opcode    = (st_q[i] == 3'd0) ? 7'($urandom) : op;
      bcond     = (st_q[i] == 3'd2) ? bc : 1'($urandom);
      halt_req  = (st_q[i] == 3'd1) ? hr : 1'($urandom);
      @(posedge clk);
      m_cyc = m_cyc + 32'd1;
      @(negedge clk);
    end
    if (ret) m_ret = m_ret + 32'd1;
    if (!listed(op)) m_ill = 1'b1;
    check_outputs("instr_end", end_st);
  endtask

  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++) begin
      opcode = 7'($urandom); bcond = 1'($urandom);
      halt_req = 1'($urandom); mem_ready = 1'($urandom);
      @(negedge clk);
      check_outputs("halt_hold", 3'd6);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    m_cyc = 0; m_ret = 0; m_ill = 1'b0;
    check_outputs("reset_async", 3'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [6:0] op;
    int         r;
    reset = 1'b0; opcode = 7'd0; bcond = 1'b0; halt_req = 1'b0; mem_ready = 1'b0;
    m_cyc = 0; m_ret = 0; m_ill = 1'b0;
    #1;
    check_outputs("reset_state", 3'd0);
    @(negedge clk);
    reset = 1'b1;

    // ADD: 4 cycles, one retire
    run_instr(ARITH, 1'b0, 1'b0, 0, 0);
    chk("add.cycle4", cycle_cnt, 32'd4);
    // branch not taken then taken
    run_instr(BRANCH, 1'b0, 1'b0, 0, 0);
    run_instr(BRANCH, 1'b1, 1'b0, 0, 0);
    do_reset();
    run_instr(BRANCH, 1'b0, 1'b0, 0, 0);
    run_instr(BRANCH, 1'b1, 1'b0, 0, 0);
    chk("branch.cycle7", cycle_cnt, 32'd7);
    chk("branch.instret2", instret_cnt, 32'd2);
    // load with 3 wait cycles in MEM
    do_reset();
    run_instr(LOAD, 1'b0, 1'b0, 0, 3);
    chk("load.cycle8", cycle_cnt, 32'd8);
    // ecall pair, second halts
    do_reset();
    run_instr(ECALL, 1'b0, 1'b0, 0, 0);
    run_instr(ECALL, 1'b0, 1'b1, 0, 0);
    chk("ecall.instret2", instret_cnt, 32'd2);
    halt_hold(10);
    chk("ecall.cycle4", cycle_cnt, 32'd4);
    // illegal opcode
    do_reset();
    run_instr(7'b0000000, 1'b0, 1'b0, 0, 0);
    chk("illegal.instret0", instret_cnt, 32'd0);
    halt_hold(3);

    // instret wrap
    do_reset();
    force dut.instret_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_cnt_q;
    m_ret = 32'hFFFF_FFFF;
    check_outputs("wrap_pre", 3'd0);
    run_instr(JAL, 1'b0, 1'b0, 0, 0);
    chk("wrap.instret0", instret_cnt, 32'd0);

    // async reset during a MEM wait
    do_reset();
    opcode = LOAD; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    chk("midmem.in_mem", current_state, 3'd4);
    @(negedge clk);
    chk("midmem.held", current_state, 3'd4);
    #2 reset = 1'b0;
    #1;
    m_cyc = 0; m_ret = 0; m_ill = 1'b0;
    check_outputs("midmem.reset", 3'd0);
    @(negedge clk);
    reset = 1'b1;
    run_instr(ARITH_IMM, 1'b0, 1'b0, 0, 0);

    // randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: op = ARITH;   1: op = ARITH_IMM; 2: op = LOAD;  3: op = STORE;
        4: op = BRANCH;  5: op = JAL;       6: op = JALR;  7: op = ECALL;
        8: op = LOAD;
        default: begin
          op = 7'($urandom);
          while (listed(op)) op = 7'($urandom);
        end
      endcase
      run_instr(op, 1'($urandom), ($urandom_range(0, 3) == 0),
                $urandom_range(0, 2), $urandom_range(0, 3));
      if (current_state == 3'd6) begin
        halt_hold(3);
        do_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
